// File: rtl/spi_resp_pkg.sv
// spi_resp_pkg
// Shared constants and the FSM state type for the SPI register responder.
//   FRAME_W   : bits per SPI frame (W + address + data)
//   CMD_W     : command bits (W + address) before the data phase
//   W_BIT     : index of the W bit in a fully shifted frame
//   BIT_CNT_W : width of the frame bit counter
package spi_resp_pkg;

    localparam int FRAME_W   = 24;
    localparam int CMD_W     = 8;
    localparam int W_BIT     = FRAME_W - 1;
    localparam int BIT_CNT_W = 5;

    typedef enum logic [2:0] {
        ST_WAIT_HI = 3'd0,
        ST_IDLE    = 3'd1,
        ST_CMD     = 3'd2,
        ST_DATA    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync
// Multi-stage synchronizer for one SPI pin with registered edge detection.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous pin input
//   lvl      : synchronized level, aligned with the rise/fall pulses
//   rise     : one-cycle pulse, SYNC_STAGES + 1 clocks after a pin rise
//   fall     : one-cycle pulse, SYNC_STAGES + 1 clocks after a pin fall
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lvl_q, lvl_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        lvl_d  = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~lvl_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & lvl_q;
    end

    // The chain resets low so a reset taken while nss is held low keeps
    // reporting "low" until the pin really goes high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign lvl  = lvl_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/spi_resp_regif.sv
// spi_resp_regif
// SPI mode-0 responder that turns 24-bit frames {W, addr[6:0], data[15:0]}
// into register-bus write strobes or read requests. Pins are oversampled.
// Ports:
//   clk, rst        : system clock (>= 8x sclk), synchronous active-high reset
//   spi_nss/sclk/mosi : SPI inputs (nss active low, MSB first)
//   spi_miso        : read data out, changes on sclk falling edges
//   spi_miso_oe     : MISO pad enable, high while selected
//   wr_stb/addr/data: one-cycle write strobe with address and data
//   rd_stb/rd_addr  : one-cycle read request; address held to frame end
//   rd_data         : read data, sampled the cycle after rd_stb
//   frame_err       : one-cycle pulse when a frame is cut short
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_WAIT_HI | after reset; waits for nss high so no partial frame decodes
// ST_IDLE    | deselected; waits for nss fall
// ST_CMD     | shifting W + address (rising edges 1..8)
// ST_DATA    | shifting data (edges 9..24); MISO serves read data
// ST_DONE    | frame complete; extra sclk edges ignored, MISO low
module spi_resp_regif
    import spi_resp_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_nss,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_stb,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              frame_err
);

    localparam logic [BIT_CNT_W-1:0] CNT_CMD   = BIT_CNT_W'(CMD_W);
    localparam logic [BIT_CNT_W-1:0] CNT_FRAME = BIT_CNT_W'(FRAME_W);

    logic nss_lvl, nss_rise, nss_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic sync_unused;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nss (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_nss),
        .lvl  (nss_lvl),
        .rise (nss_rise),
        .fall (nss_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_sclk),
        .lvl  (sclk_lvl),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_mosi),
        .lvl  (mosi_lvl),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    // Only the MOSI level and the sclk edges matter.
    assign sync_unused = sclk_lvl | mosi_rise | mosi_fall;

    state_t               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]    tx_q, tx_d;
    logic                 is_rd_q, is_rd_d;
    logic                 miso_q, miso_d;
    logic                 miso_oe_q, miso_oe_d;
    logic                 wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic                 rd_stb_q, rd_stb_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic                 frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        is_rd_d     = is_rd_q;
        miso_d      = miso_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_stb_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        frame_err_d = 1'b0;

        // Register-bus read data is valid one cycle after the request.
        if (rd_stb_q) begin
            tx_d = rd_data;
        end

        unique case (state_q)
            ST_WAIT_HI: begin
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                if (nss_lvl) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                rx_d      = '0;
                if (nss_fall) begin
                    state_d = ST_CMD;
                end
            end

            ST_CMD: begin
                miso_d = 1'b0;
                // nss rise is checked first so a coincident sclk edge is dropped.
                if (nss_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    rx_d      = {rx_q[FRAME_W-2:0], mosi_lvl};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_d == CNT_CMD) begin
                        state_d = ST_DATA;
                        is_rd_d = ~rx_d[CMD_W-1];
                        if (!rx_d[CMD_W-1]) begin
                            rd_stb_d  = 1'b1;
                            rd_addr_d = rx_d[ADDR_W-1:0];
                        end
                    end
                end
            end

            ST_DATA: begin
                if (nss_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else if (sclk_rise) begin
                    rx_d      = {rx_q[FRAME_W-2:0], mosi_lvl};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_d == CNT_FRAME) begin
                        state_d = ST_DONE;
                        miso_d  = 1'b0;
                        if (rx_d[W_BIT]) begin
                            wr_stb_d  = 1'b1;
                            wr_addr_d = rx_d[DATA_W +: ADDR_W];
                            wr_data_d = rx_d[DATA_W-1:0];
                        end
                    end
                end else if (sclk_fall && is_rd_q) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                end
            end

            ST_DONE: begin
                miso_d = 1'b0;
                if (nss_rise) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_WAIT_HI;
                miso_d  = 1'b0;
            end
        endcase

        miso_oe_d = ~nss_lvl & (state_d != ST_WAIT_HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_HI;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            is_rd_q     <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_stb_q    <= 1'b0;
            rd_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            is_rd_q     <= is_rd_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_stb_q    <= rd_stb_d;
            rd_addr_q   <= rd_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign wr_stb      = wr_stb_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_stb      = rd_stb_q;
    assign rd_addr     = rd_addr_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_resp_regif.sv
// tb_spi_resp_regif
// Drives SPI frames at sclk = clk/8 and compares register-bus activity and
// the MISO stream against a frame-level reference model.
module tb_spi_resp_regif;

    localparam int ADDR_W      = 7;
    localparam int DATA_W      = 16;
    localparam int SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              spi_nss = 1'b1;
    logic              spi_sclk = 1'b0;
    logic              spi_mosi = 1'b0;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              wr_stb;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_stb;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              frame_err;

    always #5 clk = ~clk;

    spi_resp_regif #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_nss     (spi_nss),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .wr_stb      (wr_stb),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_stb      (rd_stb),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_err   (frame_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: counts strobe cycles and keeps the last captured values.
    int                wr_seen = 0;
    int                rd_seen = 0;
    int                err_seen = 0;
    int                clash_seen = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic [DATA_W-1:0] last_wr_data = '0;
    logic [ADDR_W-1:0] last_rd_addr = '0;

    always @(negedge clk) begin
        if (wr_stb) begin
            wr_seen++;
            last_wr_addr = wr_addr;
            last_wr_data = wr_data;
        end
        if (rd_stb) begin
            rd_seen++;
            last_rd_addr = rd_addr;
        end
        if (frame_err) err_seen++;
        if ((wr_stb && rd_stb) || (frame_err && (wr_stb || rd_stb))) clash_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // SPI master, mode 0. frame is left-aligned: bit i goes out as frame[31-i].
    // MISO is sampled just before each rising edge into miso_bits[31-i].
    task automatic spi_xfer(input logic [31:0] frame, input int nbits, input int rst_at,
                            input int gap, output logic [31:0] miso_bits, output int oe_low);
        miso_bits = '0;
        oe_low    = 0;
        spi_nss   = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            spi_mosi = frame[31-i];
            tick(4);
            miso_bits[31-i] = spi_miso;
            if (rst_at < 0 && spi_miso_oe !== 1'b1) oe_low++;
            spi_sclk = 1'b1;
            tick(4);
            spi_sclk = 1'b0;
        end
        tick(2);
        spi_nss  = 1'b1;
        spi_mosi = 1'b0;
        tick(gap);
    endtask

    // Reference model: a frame either completes (>= 24 bits, no reset) and
    // acts on its W bit, or is short and flags an error. Reads serve rdval on
    // the master's rising edges 9..24.
    task automatic do_frame(input string tag, input logic [31:0] frame, input int nbits,
                            input int rst_at, input int gap, input logic [15:0] rdval);
        logic [31:0] miso_bits;
        int          oe_low;
        int          wr0, rd0, err0;
        logic        w;
        logic [6:0]  addr;
        logic [15:0] data;
        bit          complete, exp_wr, exp_rd, exp_err;
        logic [31:0] exp_miso;

        w        = frame[31];
        addr     = frame[30:24];
        data     = frame[23:8];
        complete = (nbits >= 24) && (rst_at < 0);
        exp_wr   = complete && w;
        exp_rd   = (rst_at < 0) && !w && (nbits >= 8);
        exp_err  = (rst_at < 0) && (nbits > 0) && (nbits < 24);
        exp_miso = (complete && !w) ? {8'h00, rdval, 8'h00} : 32'h0;

        rd_data = rdval;
        wr0  = wr_seen;
        rd0  = rd_seen;
        err0 = err_seen;
        spi_xfer(frame, nbits, rst_at, gap, miso_bits, oe_low);

        check_eq({tag, ".wr_cnt"}, 32'(wr_seen - wr0), 32'(exp_wr));
        check_eq({tag, ".rd_cnt"}, 32'(rd_seen - rd0), 32'(exp_rd));
        check_eq({tag, ".err_cnt"}, 32'(err_seen - err0), 32'(exp_err));
        check_eq({tag, ".miso"}, miso_bits, exp_miso);
        if (exp_wr) begin
            check_eq({tag, ".wr_addr"}, 32'(last_wr_addr), 32'(addr));
            check_eq({tag, ".wr_data"}, 32'(last_wr_data), 32'(data));
        end
        if (exp_rd) check_eq({tag, ".rd_addr"}, 32'(last_rd_addr), 32'(addr));
        if (rst_at < 0) check_eq({tag, ".oe_low"}, 32'(oe_low), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(1);
        check_eq("rst.miso", 32'(spi_miso), 32'h0);
        check_eq("rst.miso_oe", 32'(spi_miso_oe), 32'h0);
        check_eq("rst.wr_stb", 32'(wr_stb), 32'h0);
        check_eq("rst.rd_stb", 32'(rd_stb), 32'h0);
        check_eq("rst.frame_err", 32'(frame_err), 32'h0);
        check_eq("rst.wr_addr", 32'(wr_addr), 32'h0);
        check_eq("rst.wr_data", 32'(wr_data), 32'h0);
        check_eq("rst.rd_addr", 32'(rd_addr), 32'h0);
        tick(10);
        check_eq("idle.miso_oe", 32'(spi_miso_oe), 32'h0);

        do_frame("wr_831234", {24'h831234, 8'h00}, 24, -1, 8, 16'h0000);
        do_frame("rd_05", {24'h050000, 8'h00}, 24, -1, 8, 16'hA5C3);
        do_frame("short_8A", {24'h8A5A5A, 8'h00}, 12, -1, 8, 16'h0000);
        do_frame("wr_8100FF", {24'h8100FF, 8'h00}, 24, -1, 8, 16'h0000);
        do_frame("wr32_82BEEF", 32'h82BEEF5A, 32, -1, 8, 16'h0000);
        do_frame("rst_mid", {24'h8F5555, 8'h00}, 24, 10, 8, 16'h0000);
        do_frame("wr_840001", {24'h840001, 8'h00}, 24, -1, 8, 16'h0000);
        do_frame("b2b_rd1", {24'h110000, 8'h00}, 24, -1, SYNC_STAGES + 2, 16'h1357);
        do_frame("b2b_rd2", {24'h220000, 8'h00}, 24, -1, 8, 16'hECA8);

        for (int k = 0; k < 12; k++) begin
            logic        w;
            logic [6:0]  addr;
            logic [15:0] data;
            logic [7:0]  tail;
            int          nbits;
            int          kind;
            w     = 1'($urandom_range(0, 1));
            addr  = 7'($urandom);
            data  = 16'($urandom);
            tail  = 8'($urandom);
            kind  = $urandom_range(0, 3);
            if (kind == 0) nbits = w ? $urandom_range(1, 23) : $urandom_range(1, 7);
            else if (kind == 1) nbits = $urandom_range(25, 32);
            else nbits = 24;
            do_frame($sformatf("rand%0d", k), {w, addr, data, tail}, nbits, -1, 8, 16'($urandom));
        end

        check_eq("clash", 32'(clash_seen), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
